// File: rtl/max_unpool_stream.sv
// ---------------------------------------------------------------------------
// max_unpool_stream
// Expands one pooled sample plus the index of its winning position back into
// a window of LENGTH samples: the pooled value at the indexed position, zero
// everywhere else. Windows are serialised onto a valid/ready output stream.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   pooled sample and index present
//   in_ready   block can accept an input this cycle (combinational from out_ready)
//   in_data    pooled (max) value, unsigned
//   in_idx     window position of the max, 0..LENGTH-1
//   out_valid  out_data holds a valid window sample
//   out_ready  downstream accepts the sample
//   out_data   unpooled sample
//   out_last   final sample (position LENGTH-1) of a window
//   idx_err    sticky: an accepted in_idx was >= LENGTH
// ---------------------------------------------------------------------------
module max_unpool_stream #(
   parameter int unsigned BITWIDTH = 8,
   parameter int unsigned LENGTH   = 4,
   parameter int unsigned IDXW     = $clog2(LENGTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] in_data,
   input  logic [IDXW-1:0]     in_idx,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITWIDTH-1:0] out_data,
   output logic                out_last,
   output logic                idx_err
);

   localparam logic [IDXW-1:0] LAST_POS  = IDXW'(LENGTH - 1);
   localparam logic [IDXW:0]   LENGTH_EX = (IDXW + 1)'(LENGTH);

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   state_t                state;
   logic [IDXW-1:0]       pos;
   logic [IDXW-1:0]       idx_q;
   logic [BITWIDTH-1:0]   val_q;
   logic                  ready_en;

   logic                  last_beat_c;
   logic                  in_xfer_c;
   logic                  out_xfer_c;
   logic                  idx_bad_c;
   logic [IDXW-1:0]       pos_next_c;

   // Value of the window sample at position p. An out-of-range index can never
   // equal a position (pos stays below LENGTH), so such windows come out all zero.
   function automatic logic [BITWIDTH-1:0] beat_value(
      input logic [IDXW-1:0]     p,
      input logic [IDXW-1:0]     i,
      input logic [BITWIDTH-1:0] v
   );
      return (p == i) ? v : '0;
   endfunction

   assign last_beat_c = (pos == LAST_POS);
   assign pos_next_c  = pos + IDXW'(1);
   assign idx_bad_c   = ({1'b0, in_idx} >= LENGTH_EX);

   // Accept when idle, or when the final beat of the current window leaves this
   // cycle so the next window can follow without a bubble. ready_en holds this
   // low for the first cycle after reset release.
   assign in_ready   = ready_en &&
                       ((state == IDLE) || ((state == EMIT) && out_ready && last_beat_c));
   assign in_xfer_c  = in_valid && in_ready;
   assign out_xfer_c = out_valid && out_ready;

   // Window sequencer; every output except in_ready is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pos       <= '0;
         val_q     <= '0;
         idx_q     <= '0;
         ready_en  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         idx_err   <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (in_xfer_c) begin
            // New window: only possible from IDLE or on the last beat of a window.
            state     <= EMIT;
            pos       <= '0;
            val_q     <= in_data;
            idx_q     <= in_idx;
            out_valid <= 1'b1;
            out_data  <= beat_value('0, in_idx, in_data);
            out_last  <= 1'b0;
            if (idx_bad_c) begin
               idx_err <= 1'b1;
            end
         end else if ((state == EMIT) && out_xfer_c) begin
            if (last_beat_c) begin
               state     <= IDLE;
               pos       <= '0;
               out_valid <= 1'b0;
               out_data  <= '0;
               out_last  <= 1'b0;
            end else begin
               pos      <= pos_next_c;
               out_data <= beat_value(pos_next_c, idx_q, val_q);
               out_last <= (pos_next_c == LAST_POS);
            end
         end
      end
   end

endmodule
